// File: rtl/core_pkg.sv
// Shared pipeline definitions: stage indices, stall vectors and the EX multi-cycle FSM states.
package core_pkg;

  localparam int unsigned NUM_STG = 6;

  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;

  localparam logic [NUM_STG-1:0] STALL_NONE = 6'b000000;
  localparam logic [NUM_STG-1:0] STALL_ID   = 6'b000111;
  localparam logic [NUM_STG-1:0] STALL_EX   = 6'b001111;
  localparam logic [NUM_STG-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_perf_cnt.sv
// Wrapping event counter with synchronous clear; clear wins over increment.
module stall_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests and flush into a hold vector,
// and sequences multi-cycle EX occupancy.
module pipe_ctrl
  import core_pkg::*;
#(
  parameter int unsigned CNT_W  = 6,
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_stallreq,
  input  logic              mem_stallreq,
  input  logic              ex_mc_start,
  input  logic [CNT_W-1:0]  ex_mc_cycles,
  input  logic              flush_req,
  input  logic              perf_clr,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              ex_mc_busy,
  output logic              ex_mc_last,
  output logic [PERF_W-1:0] stall_cycles
);

  mc_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ex_req;
  logic [NUM_STG-1:0] stall_c;
  logic               flush_c;

  // Stall merge and EX occupancy sequencing; outputs forced low while in reset.
  always_comb begin
    ex_req  = 1'b0;
    stall_c = STALL_NONE;
    flush_c = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (state_q == RUN) begin
      ex_req = ex_mc_start && (ex_mc_cycles >= CNT_W'(2));
    end else begin
      ex_req = (cnt_q != '0);
    end

    if (rst_n) begin
      if (flush_req) begin
        flush_c = 1'b1;
      end else if (mem_stallreq) begin
        stall_c = STALL_MEM;
      end else if (ex_req) begin
        stall_c = STALL_EX;
      end else if (id_stallreq) begin
        stall_c = STALL_ID;
      end
    end

    case (state_q)
      RUN: begin
        if (ex_req) begin
          cnt_d   = ex_mc_cycles - CNT_W'(2);
          state_d = MC_BUSY;
        end
      end
      MC_BUSY: begin
        // The EX unit keeps counting even while a MEM stall holds the pipe.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!stall_c[STG_EX]) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (flush_req) begin
      state_d = RUN;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  stall_perf_cnt #(
    .W(PERF_W)
  ) u_perf (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (perf_clr),
    .inc  (stall_c[STG_PC]),
    .count(stall_cycles)
  );

  assign stall      = stall_c;
  assign flush      = flush_c;
  assign ex_mc_busy = (state_q == MC_BUSY);
  assign ex_mc_last = (state_q == MC_BUSY) && (cnt_q == '0);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, multi-cycle EX sequencing, flush, perf counter.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_stallreq, mem_stallreq, ex_mc_start, flush_req, perf_clr;
  logic [5:0]  ex_mc_cycles;
  logic [5:0]  stall;
  logic        flush, ex_mc_busy, ex_mc_last;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_ctrl #(.CNT_W(6), .PERF_W(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_stallreq (id_stallreq),
    .mem_stallreq(mem_stallreq),
    .ex_mc_start (ex_mc_start),
    .ex_mc_cycles(ex_mc_cycles),
    .flush_req   (flush_req),
    .perf_clr    (perf_clr),
    .stall       (stall),
    .flush       (flush),
    .ex_mc_busy  (ex_mc_busy),
    .ex_mc_last  (ex_mc_last),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the falling edge; outputs settle before the next rise.
  task automatic drive(input logic id, input logic mem, input logic st, input logic [5:0] n,
                       input logic fl, input logic clr);
    @(negedge clk);
    id_stallreq  = id;
    mem_stallreq = mem;
    ex_mc_start  = st;
    ex_mc_cycles = n;
    flush_req    = fl;
    perf_clr     = clr;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    id_stallreq = 1'b1; mem_stallreq = 1'b0; ex_mc_start = 1'b1; ex_mc_cycles = 6'd4;
    flush_req = 1'b0; perf_clr = 1'b0;
    #12;
    n_checks++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL reset_stall got=%b exp=000000", stall); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got=%b exp=0", flush); end
    n_checks++; if (ex_mc_busy !== 1'b0 || ex_mc_last !== 1'b0) begin n_fail++; $display("FAIL reset_mc got=%b%b exp=00", ex_mc_busy, ex_mc_last); end
    n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_perf got=%0d exp=0", stall_cycles); end
    drive(0, 0, 0, 6'd0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_id_stall();
    drive(1, 0, 0, 6'd0, 0, 0);
    n_checks++; if (stall !== 6'b000111) begin n_fail++; $display("FAIL id_stall got=%b exp=000111", stall); end
    drive(0, 0, 0, 6'd0, 0, 0);
    n_checks++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL id_release got=%b exp=000000", stall); end
    n_checks++; if (stall_cycles !== 32'd1) begin n_fail++; $display("FAIL id_perf got=%0d exp=1", stall_cycles); end
  endtask

  task automatic test_mc_op();
    for (int c = 1; c <= 3; c++) begin
      drive(0, 0, 1, 6'd4, 0, 0);
      n_checks++; if (stall !== 6'b001111) begin n_fail++; $display("FAIL mc_stall c%0d got=%b exp=001111", c, stall); end
      n_checks++; if (ex_mc_last !== 1'b0 || ex_mc_busy !== (c > 1)) begin n_fail++; $display("FAIL mc_flags c%0d got=%b%b exp=%b0", c, ex_mc_busy, ex_mc_last, (c > 1)); end
    end
    drive(0, 0, 1, 6'd4, 0, 0);
    n_checks++; if (stall !== 6'b000000 || ex_mc_last !== 1'b1 || ex_mc_busy !== 1'b1) begin n_fail++; $display("FAIL mc_last got=%b/%b%b exp=000000/11", stall, ex_mc_busy, ex_mc_last); end
    drive(0, 0, 0, 6'd0, 0, 0);
    n_checks++; if (ex_mc_busy !== 1'b0 || ex_mc_last !== 1'b0) begin n_fail++; $display("FAIL mc_exit got=%b%b exp=00", ex_mc_busy, ex_mc_last); end
    n_checks++; if (stall_cycles !== 32'd4) begin n_fail++; $display("FAIL mc_perf got=%0d exp=4", stall_cycles); end
  endtask

  task automatic test_mc_mem_stall();
    logic exp_last;
    drive(0, 0, 1, 6'd4, 0, 0);
    n_checks++; if (stall !== 6'b001111) begin n_fail++; $display("FAIL mcm_c1 got=%b exp=001111", stall); end
    for (int c = 2; c <= 6; c++) begin
      drive(0, 1, 1, 6'd4, 0, 0);
      exp_last = (c >= 4);
      n_checks++; if (stall !== 6'b011111) begin n_fail++; $display("FAIL mcm_stall c%0d got=%b exp=011111", c, stall); end
      n_checks++; if (ex_mc_last !== exp_last || ex_mc_busy !== 1'b1) begin n_fail++; $display("FAIL mcm_flags c%0d got=%b%b exp=1%b", c, ex_mc_busy, ex_mc_last, exp_last); end
    end
    drive(0, 0, 1, 6'd4, 0, 0);
    n_checks++; if (stall !== 6'b000000 || ex_mc_last !== 1'b1) begin n_fail++; $display("FAIL mcm_release got=%b/%b exp=000000/1", stall, ex_mc_last); end
    drive(0, 0, 0, 6'd0, 0, 0);
    n_checks++; if (ex_mc_busy !== 1'b0) begin n_fail++; $display("FAIL mcm_exit got=%b exp=0", ex_mc_busy); end
  endtask

  task automatic test_priority_flush();
    drive(1, 1, 1, 6'd4, 0, 0);
    n_checks++; if (stall !== 6'b011111 || flush !== 1'b0) begin n_fail++; $display("FAIL prio_all got=%b/%b exp=011111/0", stall, flush); end
    drive(1, 1, 1, 6'd4, 1, 0);
    n_checks++; if (stall !== 6'b000000 || flush !== 1'b1) begin n_fail++; $display("FAIL flush_out got=%b/%b exp=000000/1", stall, flush); end
    n_checks++; if (ex_mc_busy !== 1'b1) begin n_fail++; $display("FAIL flush_inbusy got=%b exp=1", ex_mc_busy); end
    drive(0, 0, 0, 6'd0, 0, 0);
    n_checks++; if (ex_mc_busy !== 1'b0 || ex_mc_last !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL flush_after got=%b%b%b exp=000", ex_mc_busy, ex_mc_last, flush); end
  endtask

  task automatic test_single_cycle();
    logic [5:0] n;
    for (int k = 0; k < 2; k++) begin
      n = 6'(k);
      drive(0, 0, 1, n, 0, 0);
      n_checks++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL single_stall n=%0d got=%b exp=000000", k, stall); end
      drive(0, 0, 1, n, 0, 0);
      n_checks++; if (ex_mc_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy n=%0d got=%b exp=0", k, ex_mc_busy); end
    end
    drive(0, 0, 0, 6'd0, 0, 0);
  endtask

  task automatic test_perf_wrap_clr();
    @(negedge clk);
    force u_dut.u_perf.cnt_q = 32'hFFFF_FFFF;
    #1;
    release u_dut.u_perf.cnt_q;
    drive(1, 0, 0, 6'd0, 0, 0);
    drive(0, 0, 0, 6'd0, 0, 0);
    n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL perf_wrap got=%h exp=00000000", stall_cycles); end
    drive(1, 0, 0, 6'd0, 0, 0);
    drive(1, 0, 0, 6'd0, 0, 0);
    n_checks++; if (stall_cycles !== 32'd1) begin n_fail++; $display("FAIL perf_pre got=%0d exp=1", stall_cycles); end
    drive(1, 0, 0, 6'd0, 0, 1);
    drive(0, 0, 0, 6'd0, 0, 0);
    n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL perf_clr got=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_reset_mid_op();
    drive(0, 0, 1, 6'd10, 0, 0);
    drive(1, 0, 1, 6'd10, 0, 0);
    n_checks++; if (ex_mc_busy !== 1'b1 || stall !== 6'b001111) begin n_fail++; $display("FAIL rmid_pre got=%b/%b exp=1/001111", ex_mc_busy, stall); end
    #1;
    rst_n = 1'b0;
    flush_req = 1'b1;
    #1;
    n_checks++; if (stall !== 6'b000000 || flush !== 1'b0) begin n_fail++; $display("FAIL rmid_stall got=%b/%b exp=000000/0", stall, flush); end
    n_checks++; if (ex_mc_busy !== 1'b0 || ex_mc_last !== 1'b0 || stall_cycles !== 32'd0) begin n_fail++; $display("FAIL rmid_state got=%b%b/%0d exp=00/0", ex_mc_busy, ex_mc_last, stall_cycles); end
    drive(0, 0, 0, 6'd0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 6'd0, 0, 0);
    n_checks++; if (ex_mc_busy !== 1'b0 || stall !== 6'b000000) begin n_fail++; $display("FAIL rmid_after got=%b/%b exp=0/000000", ex_mc_busy, stall); end
  endtask

  initial begin
    test_reset();
    test_id_stall();
    test_mc_op();
    test_mc_mem_stall();
    test_priority_flush();
    test_single_cycle();
    test_perf_wrap_clr();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
